// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-aligned valid/ready data-memory bus with byte enables
interface load_store_unit_if #(parameter int N = 32);
    logic         bus_valid;
    logic         bus_write;
    logic [N-1:0] bus_addr;
    logic [N-1:0] bus_wdata;
    logic [3:0]   bus_byte_en;
    logic         bus_ready;
    logic [N-1:0] bus_rdata;
    modport master(output bus_valid, bus_write, bus_addr, bus_wdata, bus_byte_en, input bus_ready, bus_rdata);
    modport slave(input bus_valid, bus_write, bus_addr, bus_wdata, bus_byte_en, output bus_ready, bus_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store unit driving a valid/ready word bus.
// Defining LSU_TIMEOUT_EN aborts a bus transfer after TIMEOUT_CYCLES cycles without ready.
module load_store_unit #(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [N-1:0]      alu_result,
    input  logic [N-1:0]      write_data,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      read_data,
    output logic              fault,
    output logic [1:0]        fault_cause,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t       state, state_n;
    logic [N-1:0] addr_q, wdata_q, wdata_rep, shifted, ext;
    logic [3:0]   be, be_q;
    logic [2:0]   f3_q;
    logic [1:0]   cause_q;
    logic         write_q, fault_q, illegal, misaligned, timeout;
    // funct3[1:0] encodes size (00 byte, 01 half, 10 word); funct3[2] marks unsigned loads
    assign illegal    = (funct3[1:0] == 2'b11) | (funct3[2] & (mem_write | funct3[1]));
    assign misaligned = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                        ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
    assign be         = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << {alu_result[1], 1'b0} : 4'b0001 << alu_result[1:0];
    assign wdata_rep  = funct3[1] ? write_data : funct3[0] ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
    assign shifted    = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    assign ext        = f3_q[1] ? shifted
                      : f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]}
                      : {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // ready on the last counted cycle still completes normally
    assign timeout = !bus.bus_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (state == BUS) ? cnt + 1'b1 : '0;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES == 0;
    assign timeout        = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE && req) state_n = (illegal | misaligned) ? DONE : BUS;
        if (state == BUS && (bus.bus_ready | timeout)) state_n = DONE;
        if (state == DONE) state_n = IDLE;
        busy            = (state == IDLE && req) || state == BUS;
        done            = state == DONE;
        fault           = (state == DONE) & fault_q;
        fault_cause     = (state == DONE) ? cause_q : 2'b00;
        bus.bus_valid   = state == BUS;
        bus.bus_write   = (state == BUS) & write_q;
        bus.bus_addr    = (state == BUS) ? {addr_q[N-1:2], 2'b00} : '0;
        bus.bus_wdata   = (state == BUS) ? wdata_q : '0;
        bus.bus_byte_en = (state == BUS) ? be_q : 4'b0000;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            cause_q   <= 2'b00;
            read_data <= '0;
        end else if (state == IDLE && req) begin
            addr_q  <= alu_result;
            wdata_q <= wdata_rep;
            be_q    <= be;
            f3_q    <= funct3;
            write_q <= mem_write;
            fault_q <= illegal | misaligned;
            cause_q <= illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
        end else if (state == BUS) begin
            if (bus.bus_ready && !write_q) read_data <= ext;
            if (timeout) begin
                fault_q <= 1'b1;
                cause_q <= 2'b11;
            end
        end
endmodule
